// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART_tx between NUM_REQ byte-stream requesters.
// Define UART_ARB_TIMEOUT_EN to revoke a grant whose owner stalls byte_vld for TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   byte_vld,
    input  logic [8*NUM_REQ-1:0] byte_data,
    input  logic [NUM_REQ-1:0]   byte_last,
    output logic [NUM_REQ-1:0]   byte_ack,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 trmt,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 abort
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("uart_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] last_gnt;
    logic [IW-1:0] win, cand;
    logic          win_vld;
    logic          last_q;
    logic          do_grant, do_load, do_release, do_abort;
    logic          tmo_hit;
    int            idx;
    logic [7:0]    bytes [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) bytes[i] = byte_data[8*i +: 8];
    end

    // last_gnt doubles as the owner index while a grant is held
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_gnt) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IW'(idx);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    tmo_cnt <= '0;
        else if (state != LOAD || byte_vld[last_gnt]) tmo_cnt <= '0;
        else if (req[last_gnt] && !tmo_hit)         tmo_cnt <= tmo_cnt + CW'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        byte_ack   = '0;
        do_grant   = 1'b0;
        do_load    = 1'b0;
        do_release = 1'b0;
        do_abort   = 1'b0;
        case (state)
            IDLE: if (win_vld) begin
                do_grant  = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                if (byte_vld[last_gnt]) begin
                    byte_ack[last_gnt] = 1'b1;
                    do_load            = 1'b1;
                    state_nxt          = SEND;
                end else if (!req[last_gnt]) begin
                    do_release = 1'b1;
                    state_nxt  = IDLE;
                end else if (tmo_hit) begin
                    do_abort   = 1'b1;
                    do_release = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            SEND: state_nxt = WAIT_DONE;
            WAIT_DONE: if (tx_done) begin
                if (last_q) begin
                    do_release = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            last_gnt <= IW'(NUM_REQ - 1);
            tx_data  <= 8'h00;
            last_q   <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state <= state_nxt;
            abort <= do_abort;
            if (do_grant) begin
                gnt      <= NUM_REQ'(1) << win;
                last_gnt <= win;
            end
            if (do_release) gnt <= '0;
            if (do_load) begin
                tx_data <= bytes[last_gnt];
                last_q  <= byte_last[last_gnt];
            end
        end
    end

    assign trmt = (state == SEND);
    assign busy = (state != IDLE);

endmodule
